// File: rtl/dice_roller_ndigit.sv
// Multi-digit BCD dice roller: debounced buttons, free-running roll,
// optional accumulate, and a leading-zero-blanked scanned 7-seg display.
module dice_roller_ndigit #(
  parameter int DIGITS        = 3,
  parameter int PRESCALE      = 1024,
  parameter int DEB_TICKS     = 2,
  parameter int TIMEOUT_TICKS = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            btn,
  input  logic                  add_mode,
  output logic [4*DIGITS-1:0]   result,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROLL,
    S_COMMIT
  } state_t;

  logic [PW-1:0]       pre_q;
  logic                tick;
  logic [6:0]          deb_q;
  logic [DW-1:0]       dcnt_q [7];
  state_t              state_q, state_d;
  logic [2:0]          sel_q, sel_d;
  logic [7:0]          roll_q, roll_d;
  logic [4*DIGITS-1:0] result_q, result_d;
  logic                valid_q, valid_d;
  logic [7:0]          tmo_q, tmo_d;
  logic [1:0]          scan_q;
  logic                show;
  logic [15:0]         res_ext;
  logic [15:0]         roll_ext;
  logic [4*DIGITS-1:0] sum_w;
  logic [4:0]          dsum;
  logic                carry;
  logic [3:0]          nz_from;
  logic                nz_acc;
  logic                en_ok;

  function automatic logic [7:0] max_of(input logic [2:0] s);
    logic [7:0] m;
    unique case (s)
      3'd0:    m = 8'h04;
      3'd1:    m = 8'h06;
      3'd2:    m = 8'h08;
      3'd3:    m = 8'h10;
      3'd4:    m = 8'h12;
      3'd5:    m = 8'h20;
      default: m = 8'h99;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] lowest(input logic [6:0] b);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 6; i >= 0; i--)
      if (b[i]) r = 3'(i);
    return r;
  endfunction

  function automatic logic [7:0] bcd_dn(input logic [7:0] r,
                                        input logic [2:0] s);
    logic [7:0] n;
    if (s == 3'd6 && r == 8'h00)
      n = 8'h99;
    else if (s != 3'd6 && r == 8'h01)
      n = max_of(s);
    else if (r[3:0] == 4'd0)
      n = {r[7:4] - 4'd1, 4'd9};
    else
      n = {r[7:4], r[3:0] - 4'd1};
    return n;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] g;
    unique case (d)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  assign tick     = (pre_q == '0);
  assign res_ext  = 16'(result_q);
  assign roll_ext = {8'h00, roll_q};
  assign show     = (tmo_q != 8'd0);
  assign busy     = (state_q != S_IDLE);
  assign result   = result_q;

  // Prescaler: free-running 0..PRESCALE-1, tick on count zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pre_q <= '0;
    else if (pre_q == PW'(PRESCALE - 1))
      pre_q <= '0;
    else
      pre_q <= pre_q + 1'b1;
  end

  // Debounce: flip a level after DEB_TICKS differing tick samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= '0;
      for (int i = 0; i < 7; i++) dcnt_q[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < 7; i++) begin
        if (btn[i] != deb_q[i]) begin
          if (dcnt_q[i] == DW'(DEB_TICKS - 1)) begin
            deb_q[i]  <= btn[i];
            dcnt_q[i] <= '0;
          end else begin
            dcnt_q[i] <= dcnt_q[i] + 1'b1;
          end
        end else begin
          dcnt_q[i] <= '0;
        end
      end
    end
  end

  // Saturating BCD sum of the held result and the current roll.
  always_comb begin
    sum_w = '0;
    carry = 1'b0;
    dsum  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dsum = {1'b0, res_ext[4*i +: 4]} + {1'b0, roll_ext[4*i +: 4]}
           + {4'b0, carry};
      if (dsum > 5'd9) begin
        sum_w[4*i +: 4] = 4'(dsum + 5'd6);
        carry           = 1'b1;
      end else begin
        sum_w[4*i +: 4] = dsum[3:0];
        carry           = 1'b0;
      end
    end
    if (carry) sum_w = {DIGITS{4'h9}};
  end

  // Next-state and datapath updates for the roll FSM and timeout.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    roll_d   = roll_q;
    result_d = result_q;
    valid_d  = valid_q;
    tmo_d    = tmo_q;
    if (tick && tmo_q != 8'd0) tmo_d = tmo_q - 8'd1;
    unique case (state_q)
      S_IDLE: begin
        if (|deb_q) begin
          state_d = S_ROLL;
          sel_d   = lowest(deb_q);
          roll_d  = max_of(lowest(deb_q));
        end
      end
      S_ROLL: begin
        roll_d = bcd_dn(roll_q, sel_q);
        if (!deb_q[sel_q]) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        state_d  = S_IDLE;
        result_d = (add_mode && valid_q) ? sum_w
                                         : roll_ext[4*DIGITS-1:0];
        valid_d  = 1'b1;
        tmo_d    = 8'(TIMEOUT_TICKS);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, roll and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      roll_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      roll_q   <= roll_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      tmo_q    <= tmo_d;
    end
  end

  // Display scan index, one digit per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      scan_q <= '0;
    else if (scan_q == 2'(DIGITS - 1))
      scan_q <= '0;
    else
      scan_q <= scan_q + 2'd1;
  end

  // Mark which digit positions have a nonzero digit at or above them.
  always_comb begin
    nz_acc  = 1'b0;
    nz_from = '0;
    for (int k = 3; k >= 0; k--) begin
      nz_acc     = nz_acc | (res_ext[4*k +: 4] != 4'd0);
      nz_from[k] = nz_acc;
    end
  end

  assign en_ok = show && (state_q == S_IDLE)
              && ((scan_q == 2'd0) || nz_from[scan_q]);

  assign seg = seg_of(res_ext[{scan_q, 2'b00} +: 4]);

  // Digit enable: one-hot on the scanned digit, blanked leading zeros.
  always_comb begin
    dig_en = '0;
    for (int i = 0; i < DIGITS; i++)
      dig_en[i] = en_ok && (scan_q == 2'(i));
  end

endmodule
